// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and width helpers for the NxN matrix-multiply controller
package matmul_pkg;

    // Controller phases: load operands, run the MAC sequence, pulse completion.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mm_state_t;

    // Default geometry of the original 2x2, 8-bit controller.
    localparam int MM_N_DEFAULT  = 2;
    localparam int MM_DW_DEFAULT = 8;

    // Row/column index width; a 1-bit index is the floor even for tiny N.
    function automatic int mm_iw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Accumulator width: full product plus headroom for N partial sums.
    function automatic int mm_aw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_ctrl_n_mac_lane.sv
// rtl/matmul_ctrl_n_mac_lane.sv - sequential multiply-accumulate lane with C-preload and last-k write strobe
module matmul_mac_lane
    import matmul_pkg::*;
#(
    parameter int DW = MM_DW_DEFAULT,
    parameter int AW = mm_aw(MM_N_DEFAULT, MM_DW_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_first,
    input  logic          i_last,
    input  logic          i_init_sel,
    input  logic [AW-1:0] i_c_old,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [AW-1:0] o_sum,
    output logic          o_wr
);

    typedef logic [AW-1:0]   acc_t;
    typedef logic [2*DW-1:0] prod_t;

    prod_t w_prod;
    acc_t  w_base;
    acc_t  r_acc;

    // Start each dot product from zero or the old C value, then add the zero-extended product.
    always_comb begin
        w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
        w_base = i_first ? (i_init_sel ? i_c_old : '0) : r_acc;
        o_sum  = w_base + {{(AW - 2 * DW){1'b0}}, w_prod};
        o_wr   = i_en && i_last;
    end

    // Running partial sum; stale contents are harmless since k==0 never reads them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/matmul_ctrl_n.sv
// rtl/matmul_ctrl_n.sv - NxN load/compute/readout matmul controller (readout clamp under MATMUL_CTRL_SAT_EN)
module matmul_ctrl_n
    import matmul_pkg::*;
#(
    parameter int N  = MM_N_DEFAULT,
    parameter int DW = MM_DW_DEFAULT,
    parameter int IW = mm_iw(N),
    parameter int AW = mm_aw(N, DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic          load_sel_ab,
    input  logic [IW-1:0] load_row,
    input  logic [IW-1:0] load_col,
    input  logic [DW-1:0] in_data,
    input  logic          acc_mode,
    input  logic          out_en,
    input  logic [IW-1:0] out_row,
    input  logic [IW-1:0] out_col,
    output logic [AW-1:0] out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);

    localparam int NN = N * N;
    localparam int XW = $clog2(NN);

    typedef logic [DW-1:0] elem_t;
    typedef logic [AW-1:0] acc_t;
    typedef logic [XW-1:0] idx_t;

    mm_state_t     r_state;
    mm_state_t     w_state_nxt;

    elem_t         r_a [NN];
    elem_t         r_b [NN];
    acc_t          r_c [NN];
    logic [NN-1:0] r_a_flg;
    logic [NN-1:0] r_b_flg;

    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_k;
    logic          r_acc_mode_q;

    logic          w_load_ok;
    logic          w_rd_in;
    logic          w_all_loaded;
    logic          w_in_compute;
    logic          w_first_k;
    logic          w_last_k;
    logic          w_last_j;
    logic          w_last_i;
    idx_t          w_ld_idx;
    idx_t          w_rd_idx;
    idx_t          w_ij_idx;
    idx_t          w_ik_idx;
    idx_t          w_kj_idx;
    acc_t          w_mac_sum;
    logic          w_mac_wr;
    acc_t          w_c_rd;
    acc_t          w_rd_data;

    // Row-major flat index into the N*N element stores.
    function automatic idx_t f_idx(input logic [IW-1:0] row, input logic [IW-1:0] col);
        return XW'(int'(row) * N + int'(col));
    endfunction

    // Index decode, range checks and loop-end detection.
    always_comb begin
        w_ld_idx     = f_idx(load_row, load_col);
        w_rd_idx     = f_idx(out_row, out_col);
        w_ij_idx     = f_idx(r_i, r_j);
        w_ik_idx     = f_idx(r_i, r_k);
        w_kj_idx     = f_idx(r_k, r_j);
        w_load_ok    = load_en && (r_state == IDLE)
                       && (int'(load_row) < N) && (int'(load_col) < N);
        w_rd_in      = (int'(out_row) < N) && (int'(out_col) < N);
        w_all_loaded = (&r_a_flg) && (&r_b_flg);
        w_in_compute = (r_state == COMPUTE);
        w_first_k    = (r_k == '0);
        w_last_k     = (r_k == IW'(N - 1));
        w_last_j     = (r_j == IW'(N - 1));
        w_last_i     = (r_i == IW'(N - 1));
    end

    // Next-state decode; busy/done are pure functions of the current phase.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_all_loaded) begin
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (w_last_i && w_last_j && w_last_k) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Phase register; reset aborts any compute in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulate mode is frozen at the moment compute starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_mode_q <= 1'b0;
        end else if ((r_state == IDLE) && w_all_loaded) begin
            r_acc_mode_q <= acc_mode;
        end
    end

    // Nested i/j/k walk with k fastest; counters sit at zero outside compute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_in_compute) begin
            if (w_last_k) begin
                r_k <= '0;
                if (w_last_j) begin
                    r_j <= '0;
                    r_i <= w_last_i ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end else begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end
    end

    // Operand stores and loaded flags; flags drop during DONE so every run needs a full reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int x = 0; x < NN; x++) begin
                r_a[x] <= '0;
                r_b[x] <= '0;
            end
            r_a_flg <= '0;
            r_b_flg <= '0;
        end else begin
            if (w_load_ok) begin
                if (load_sel_ab) begin
                    r_b[w_ld_idx]     <= in_data;
                    r_b_flg[w_ld_idx] <= 1'b1;
                end else begin
                    r_a[w_ld_idx]     <= in_data;
                    r_a_flg[w_ld_idx] <= 1'b1;
                end
            end
            if (r_state == DONE) begin
                r_a_flg <= '0;
                r_b_flg <= '0;
            end
        end
    end

    matmul_mac_lane #(
        .DW (DW),
        .AW (AW)
    ) u_mac_lane (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_in_compute),
        .i_first    (w_first_k),
        .i_last     (w_last_k),
        .i_init_sel (r_acc_mode_q),
        .i_c_old    (r_c[w_ij_idx]),
        .i_a        (r_a[w_ik_idx]),
        .i_b        (r_b[w_kj_idx]),
        .o_sum      (w_mac_sum),
        .o_wr       (w_mac_wr)
    );

    // Result store: each C element is written once, on the last-k edge of its dot product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int x = 0; x < NN; x++) begin
                r_c[x] <= '0;
            end
        end else if (w_mac_wr) begin
            r_c[w_ij_idx] <= w_mac_sum;
        end
    end

    // Readout value: out-of-range indices read as zero; optional clamp to element range.
    always_comb begin
        w_c_rd = w_rd_in ? r_c[w_rd_idx] : '0;
`ifdef MATMUL_CTRL_SAT_EN
        w_rd_data = (w_c_rd > {{(AW - DW){1'b0}}, {DW{1'b1}}})
                    ? {{(AW - DW){1'b0}}, {DW{1'b1}}} : w_c_rd;
`else
        w_rd_data = w_c_rd;
`endif
    end

    // Registered read port; data holds while no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (out_en) begin
            out_data  <= w_rd_data;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matmul_ctrl_n.sv
// tb/tb_matmul_ctrl_n.sv - directed self-checking bench for matmul_ctrl_n (N=2/DW=8 and N=3/DW=4)
module tb_matmul_ctrl_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=2, DW=8 instance: IW=1, AW=17
    logic        ld_en2, ld_sel2, acc2, oen2;
    logic [0:0]  ld_row2, ld_col2, orow2, ocol2;
    logic [7:0]  in2;
    logic [16:0] od2;
    logic        ov2, busy2, done2;

    // N=3, DW=4 instance: IW=2, AW=10
    logic        ld_en3, ld_sel3, acc3, oen3;
    logic [1:0]  ld_row3, ld_col3, orow3, ocol3;
    logic [3:0]  in3;
    logic [9:0]  od3;
    logic        ov3, busy3, done3;

    matmul_ctrl_n u_dut2 (
        .clk(clk), .rst(rst), .load_en(ld_en2), .load_sel_ab(ld_sel2),
        .load_row(ld_row2), .load_col(ld_col2), .in_data(in2), .acc_mode(acc2),
        .out_en(oen2), .out_row(orow2), .out_col(ocol2), .out_data(od2),
        .out_valid(ov2), .busy(busy2), .done(done2)
    );

    matmul_ctrl_n #(.N(3), .DW(4)) u_dut3 (
        .clk(clk), .rst(rst), .load_en(ld_en3), .load_sel_ab(ld_sel3),
        .load_row(ld_row3), .load_col(ld_col3), .in_data(in3), .acc_mode(acc3),
        .out_en(oen3), .out_row(orow3), .out_col(ocol3), .out_data(od3),
        .out_valid(ov3), .busy(busy3), .done(done3)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int A1 [4] = '{1, 2, 3, 4};
    int B1 [4] = '{5, 6, 7, 8};
    int C1 [4] = '{19, 22, 43, 50};
    int C2 [4] = '{38, 44, 86, 100};
    int F1 [4] = '{255, 255, 255, 255};
    int A3 [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int B3 [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
`ifdef MATMUL_CTRL_SAT_EN
    int C_FULL = 255;
`else
    int C_FULL = 130050;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ld2(input logic sel, input int r, input int c, input int d);
        ld_en2  = 1'b1;
        ld_sel2 = sel;
        ld_row2 = 1'(r);
        ld_col2 = 1'(c);
        in2     = 8'(d);
        tick();
        ld_en2  = 1'b0;
    endtask

    task automatic ld2_mat(input int a [4], input int b [4]);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) ld2(1'b0, r, c, a[r*2+c]);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) ld2(1'b1, r, c, b[r*2+c]);
    endtask

    task automatic ld3(input logic sel, input int r, input int c, input int d);
        ld_en3  = 1'b1;
        ld_sel3 = sel;
        ld_row3 = 2'(r);
        ld_col3 = 2'(c);
        in3     = 4'(d);
        tick();
        ld_en3  = 1'b0;
    endtask

    task automatic wait_done2(output int cyc);
        cyc = 0;
        while (!done2 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done3(output int cyc);
        cyc = 0;
        while (!done3 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic rd2(input string tag, input int r, input int c, input int exp);
        oen2  = 1'b1;
        orow2 = 1'(r);
        ocol2 = 1'(c);
        tick();
        chk({tag, "_valid"}, 32'(ov2), 32'd1);
        chk(tag, 32'(od2), exp);
        oen2  = 1'b0;
    endtask

    task automatic rd2_mat(input string tag, input int exp [4]);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) rd2($sformatf("%s_c%0d%0d", tag, r, c), r, c, exp[r*2+c]);
    endtask

    task automatic rd3(input string tag, input int r, input int c, input int exp);
        oen3  = 1'b1;
        orow3 = 2'(r);
        ocol3 = 2'(c);
        tick();
        chk({tag, "_valid"}, 32'(ov3), 32'd1);
        chk(tag, 32'(od3), exp);
        oen3  = 1'b0;
    endtask

    initial begin
        int cyc;
        ld_en2 = 0; ld_sel2 = 0; ld_row2 = 0; ld_col2 = 0; in2 = 0; acc2 = 0;
        oen2 = 0; orow2 = 0; ocol2 = 0;
        ld_en3 = 0; ld_sel3 = 0; ld_row3 = 0; ld_col3 = 0; in3 = 0; acc3 = 0;
        oen3 = 0; orow3 = 0; ocol3 = 0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_done", 32'(done2), 0);
        chk("rst_valid", 32'(ov2), 0);
        chk("rst_data", 32'(od2), 0);
        chk("rst_busy3", 32'(busy3), 0);

        // basic multiply
        ld2_mat(A1, B1);
        chk("t1_busy_flag_edge", 32'(busy2), 0);
        tick();
        chk("t1_busy_rise", 32'(busy2), 1);
        wait_done2(cyc);
        chk("t1_cycles", cyc, 8);
        chk("t1_done", 32'(done2), 1);
        tick();
        chk("t1_done_pulse", 32'(done2), 0);
        chk("t1_busy_fall", 32'(busy2), 0);
        rd2_mat("t1", C1);
        tick();
        chk("t1_valid_drop", 32'(ov2), 0);
        chk("t1_data_hold", 32'(od2), 50);

        // accumulate mode
        acc2 = 1'b1;
        ld2_mat(A1, B1);
        tick();
        acc2 = 1'b0;
        wait_done2(cyc);
        chk("t2_cycles", cyc, 8);
        tick();
        rd2_mat("t2", C2);

        // full-scale operands
        ld2_mat(F1, F1);
        tick();
        wait_done2(cyc);
        chk("t3_cycles", cyc, 8);
        tick();
        rd2_mat("t3", '{C_FULL, C_FULL, C_FULL, C_FULL});

        // incomplete load never starts; loads during compute are ignored
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) ld2(1'b0, r, c, A1[r*2+c]);
        ld2(1'b1, 0, 0, 5);
        ld2(1'b1, 0, 1, 6);
        ld2(1'b1, 1, 0, 7);
        for (int t = 0; t < 4; t++) tick();
        chk("t4_no_busy", 32'(busy2), 0);
        chk("t4_no_done", 32'(done2), 0);
        ld2(1'b1, 1, 1, 8);
        tick();
        chk("t4_busy", 32'(busy2), 1);
        ld2(1'b0, 0, 0, 9);
        ld2(1'b1, 0, 0, 9);
        wait_done2(cyc);
        chk("t4_cycles", cyc, 6);
        tick();
        rd2_mat("t4", C1);

        // reset in the middle of compute
        ld2_mat(A1, B1);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy2), 0);
        chk("t5_done", 32'(done2), 0);
        tick();
        rst = 1'b0;
        rd2_mat("t5", '{0, 0, 0, 0});
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) ld2(1'b0, r, c, A1[r*2+c]);
        tick();
        tick();
        chk("t5_flags_cleared", 32'(busy2), 0);

        // N=3, DW=4: identity * B
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) ld3(1'b0, r, c, A3[r*3+c]);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) ld3(1'b1, r, c, B3[r*3+c]);
        tick();
        chk("t6_busy", 32'(busy3), 1);
        wait_done3(cyc);
        chk("t6_cycles", cyc, 27);
        tick();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) rd3($sformatf("t6_c%0d%0d", r, c), r, c, B3[r*3+c]);
        rd3("t6_oor", 3, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl_n.md
Name: matmul_ctrl_n

Overview:
- Parametrised successor to the fixed 2x2 load/compute/readout controller: an NxN matrix-multiply controller.
- Host writes elements of A and B one per cycle, the block computes C = A*B (or C += A*B) with one sequential MAC per cycle, then C is read back by row/col index.
- Sits between the tt_um top-level pin mux and the matrix datapath.
- Adds what the fixed version lacks: generic N and data width, wide accumulator, accumulate mode, busy status and registered read-valid.

Parameters:
- N, 2, matrix dimension (2..8).
- DW, 8, element width of A and B (unsigned).
- IW, $clog2(N) (min 1), row/col index width.
- AW, 2*DW+$clog2(N), width of C elements and accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- load_en  in  1  write strobe for one element.
- load_sel_ab  in  1  0=A, 1=B.
- load_row  in  IW  element row.
- load_col  in  IW  element column.
- in_data  in  DW  element value.
- acc_mode  in  1  1 = accumulate into existing C; sampled on COMPUTE entry.
- out_en  in  1  read request.
- out_row  in  IW  read row.
- out_col  in  IW  read column.
- out_data  out  AW  registered C[out_row][out_col].
- out_valid  out  1  registered copy of out_en.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at end of compute.

Behaviour:
- Reset: state IDLE; A, B, C, accumulator, loaded flags, i/j/k counters, out_data, out_valid, done, busy all 0. Reset mid-COMPUTE aborts immediately; C is zeroed.
- Storage: A and B each N*N x DW; C is N*N x AW; two N*N-bit loaded vectors.
- Load: accepted only in IDLE with load_en=1 and row<N and col<N. Writes the element and sets its loaded bit.
  - Out-of-range indices (N not a power of 2) are ignored.
  - Loads outside IDLE are ignored; they must not modify A/B/flags.
  - Rewriting an element overwrites it; flag stays set.
- State machine IDLE -> COMPUTE -> DONE -> IDLE.
  - IDLE -> COMPUTE when all A flags and all B flags are set, evaluated on registered flags. COMPUTE is entered on the edge after the edge that set the final flag.
  - COMPUTE: counters i (row), j (col), k (inner), k fastest, one MAC per cycle, exactly N^3 cycles.
    - k==0: acc = (acc_mode_q ? C[i][j] : 0) + A[i][0]*B[0][j].
    - Else acc += A[i][k]*B[k][j].
    - At k==N-1 the final sum is written to C[i][j] on that edge.
  - DONE: one cycle, done=1. Clears both loaded vectors. Returns to IDLE; new loads are accepted from the following cycle.
  - C elements not yet reached during COMPUTE hold their old values.
- Arithmetic: unsigned. Products are DW*2 bits, zero-extended to AW. In accumulate mode, overflow wraps modulo 2^AW.
- Readout: any state. out_data <= C[out_row][out_col] and out_valid <= 1 one cycle after out_en=1.
  - When out_en=0, out_valid <= 0 and out_data holds.
  - Out-of-range indices return 0 with out_valid=1.
  - A read of C[i][j] on the same cycle it is written returns the old value.
- Simultaneous load_en and final-flag completion: the load is applied normally; completion is seen next cycle.

Optional Feature:
- Macro MATMUL_CTRL_SAT_EN.
- Defined: readout clamps C to unsigned DW range; out_data = min(C, 2^DW-1), zero-extended to AW. Stored C remains full width.
- Undefined: out_data is the raw AW-bit C.

Decomposition:
- Package matmul_pkg:
  - state enum mm_state_t {IDLE, COMPUTE, DONE}.
  - Localparam helpers for IW and AW.
  - Element typedefs parameterised by width.
- One sub-module matmul_mac_lane: registered accumulator with init-select (zero / C-preload), multiply-add, and last-k write strobe.

Test Plan:
- N=2, DW=8: load A=[[1,2],[3,4]], B=[[5,6],[7,8]], acc_mode=0 -> busy rises next cycle; done pulses after 8 COMPUTE cycles; reads give C=[[19,22],[43,50]], each with out_valid one cycle after out_en.
- Reload the same A/B with acc_mode=1 -> C=[[38,44],[86,100]].
- All A/B elements = 255 -> C every element = 130050 (fits AW=17). With MATMUL_CTRL_SAT_EN, each read returns 255.
- Load all of A and only 3 of 4 B elements -> no busy, no done. Load in_data=9 during COMPUTE -> A/B unchanged and result unaffected.
- Assert rst at COMPUTE cycle 4 -> busy=0, done=0, all C reads return 0, flags cleared (a full reload is required before the next start).
- N=3, DW=4, A=identity, B=[[1..9]] -> done after 27 cycles; C equals B. A read at row=3 (out of range) returns 0.
